// File: rtl/fma_cluster_feeder_if.sv
// Edge-lane bundle between the feeder and the FMA cluster: per-lane req/data out, per-lane busy back.
interface fma_cluster_feeder_if #(
  parameter int N  = 3,
  parameter int FW = 32
);
  logic [N-1:0]    a_req_out;
  logic [FW*N-1:0] a_data_out;
  logic [N-1:0]    a_busy_in;
  logic [N-1:0]    b_req_out;
  logic [FW*N-1:0] b_data_out;
  logic [N-1:0]    b_busy_in;

  modport master (
    output a_req_out, a_data_out, b_req_out, b_data_out,
    input  a_busy_in, b_busy_in
  );

  modport slave (
    input  a_req_out, a_data_out, b_req_out, b_data_out,
    output a_busy_in, b_busy_in
  );
endinterface

// File: rtl/fma_cluster_feeder.sv
// Captures A and B on start and streams them into the cluster edges one k-slice per beat.
// Registered outputs; beats wait for all edge lanes idle and a GAP-cycle spacing.
module fma_cluster_feeder #(
  parameter int N   = 3,
  parameter int FW  = 32,
  parameter int GAP = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_in,
  input  logic [FW*N*N-1:0]   matrix_a_in,
  input  logic [FW*N*N-1:0]   matrix_b_in,
  fma_cluster_feeder_if.master edge_if,
  output logic                busy_out,
  output logic                done_out
);
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(N - 1);
  localparam logic [3:0]    GAP_V  = 4'(GAP);

  typedef enum logic [1:0] {IDLE, FEED, FLUSH} state_t;

  state_t              state_q, state_d;
  logic [KW-1:0]       k_q, k_d;
  logic [3:0]          gap_q, gap_d;
  logic [FW*N*N-1:0]   a_mat_q, a_mat_d, b_mat_q, b_mat_d;
  logic [N-1:0]        a_req_q, a_req_d, b_req_q, b_req_d;
  logic [FW*N-1:0]     a_data_q, a_data_d, b_data_q, b_data_d;
  logic                busy_q, busy_d, done_q, done_d;
  logic                any_busy;

  assign any_busy = (|edge_if.a_busy_in) || (|edge_if.b_busy_in);

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    gap_d    = gap_q;
    a_mat_d  = a_mat_q;
    b_mat_d  = b_mat_q;
    busy_d   = busy_q;
    a_req_d  = '0;
    b_req_d  = '0;
    a_data_d = '0;
    b_data_d = '0;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_in) begin
          a_mat_d = matrix_a_in;
          b_mat_d = matrix_b_in;
          k_d     = '0;
          gap_d   = '0;
          busy_d  = 1'b1;
          state_d = FEED;
        end
      end
      FEED: begin
        if (gap_q != 4'd0) begin
          gap_d = gap_q - 4'd1;
        end else if (!any_busy) begin
          // Beat k: A column k down the left edge, B row k across the top edge.
          a_req_d = '1;
          b_req_d = '1;
          for (int i = 0; i < N; i++) begin
            a_data_d[FW*i +: FW] = a_mat_q[FW*(i*N + int'(k_q)) +: FW];
            b_data_d[FW*i +: FW] = b_mat_q[FW*(int'(k_q)*N + i) +: FW];
          end
          gap_d = GAP_V;
          if (k_q == K_LAST) state_d = FLUSH;
          else               k_d     = k_q + KW'(1);
        end
      end
      FLUSH: begin
        if (gap_q != 4'd0) begin
          gap_d = gap_q - 4'd1;
        end else if (!any_busy) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      k_q      <= '0;
      gap_q    <= '0;
      a_mat_q  <= '0;
      b_mat_q  <= '0;
      a_req_q  <= '0;
      b_req_q  <= '0;
      a_data_q <= '0;
      b_data_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      gap_q    <= gap_d;
      a_mat_q  <= a_mat_d;
      b_mat_q  <= b_mat_d;
      a_req_q  <= a_req_d;
      b_req_q  <= b_req_d;
      a_data_q <= a_data_d;
      b_data_q <= b_data_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign edge_if.a_req_out  = a_req_q;
  assign edge_if.a_data_out = a_data_q;
  assign edge_if.b_req_out  = b_req_q;
  assign edge_if.b_data_out = b_data_q;
  assign busy_out           = busy_q;
  assign done_out           = done_q;
endmodule
